// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the execute-stage requesters and the
// shared-ALU arbiter. Requester i owns slice i of every packed vector.
interface alu_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [4*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [31:0]          rsp_data;
    logic                 rsp_err;

    // Requester side
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// One op in flight: IDLE accepts, EXEC drives the ALU and captures the
// result, RESP holds it until the winner takes it.
module alu_arbiter #(
    parameter int NREQ       = 2,
    parameter bit SHAMT_MASK = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic [3:0]   alu_op_o,
    output logic [31:0]  alu_r1_o,
    output logic [31:0]  alu_r2_o,
    input  logic [31:0]  alu_out_i
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     data_q, data_d;
    logic            err_q, err_d;

    logic            win_found;
    logic [IW-1:0]   win_id;
    logic            op_illegal;
    logic            op_shift;
    logic [NREQ-1:0] grant_oh;
    logic [NREQ-1:0] rsp_oh;

    // Pick the first valid requester after the last one served, wrapping around
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IW'(idx);
            end
        end
    end

    // The ALU has no default case, so illegal codes are steered to ADD and
    // the result discarded. ALU inputs come straight from the latched op so
    // they only toggle when a new op is accepted.
    assign op_illegal = (op_q > OP_LAST);
    assign op_shift   = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);
    assign alu_op_o   = op_illegal ? 4'd0 : op_q;
    assign alu_r1_o   = a_q;
    assign alu_r2_o   = (SHAMT_MASK && op_shift) ? {27'b0, b_q[4:0]} : b_q;

    assign bus.req_ready = grant_oh;
    assign bus.rsp_valid = rsp_oh;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;

    // Next-state and handshake strobes for the IDLE/EXEC/RESP sequence
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        data_d   = data_q;
        err_d    = err_q;
        grant_oh = '0;
        rsp_oh   = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_oh[win_id] = 1'b1;
                    op_d    = bus.req_op[int'(win_id)*4 +: 4];
                    a_d     = bus.req_a[int'(win_id)*32 +: 32];
                    b_d     = bus.req_b[int'(win_id)*32 +: 32];
                    ptr_d   = win_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = op_illegal ? 32'd0 : alu_out_i;
                err_d   = op_illegal;
                state_d = RESP;
            end
            RESP: begin
                rsp_oh[ptr_q] = 1'b1;
                if (bus.rsp_ready[ptr_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant pointer, latched op and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
endmodule
